// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: four rotating line buffers fed by a raster pixel stream.
// Once three full lines are buffered, a one-line read pass emits one 3x3
// window per cycle; o_intr pulses as each line buffer is released.
module conv_window_ctrl #(
   parameter int IMG_WIDTH = 512
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  i_pixel_data,
   input  logic        i_pixel_data_valid,
   output logic        o_pixel_ready,
   output logic [71:0] o_pixel_data,
   output logic        o_pixel_data_valid,
   output logic        o_intr
);

   localparam int PW = $clog2(IMG_WIDTH);
   localparam int CW = $clog2(4*IMG_WIDTH+1);
   localparam logic [PW-1:0] LAST  = PW'(IMG_WIDTH-1);
   localparam logic [PW:0]   LASTX = (PW+1)'(IMG_WIDTH-1);
   localparam logic [CW-1:0] FULL  = CW'(4*IMG_WIDTH);
   localparam logic [CW-1:0] THREE = CW'(3*IMG_WIDTH);

   typedef enum logic {IDLE, RD} state_e;

   state_e         state_q, state_d;
   logic [7:0]     mem_q [4][IMG_WIDTH];
   logic [1:0]     wr_lb_q, wr_lb_d, rd_lb_q, rd_lb_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  pix_count_q, pix_count_d;
   logic           wr_en, rd_en, rd_last;
   logic [71:0]    win_d, win_q;
   logic           vld_q, intr_q;
   logic [1:0]     lb;
   logic [PW:0]    col;

   assign o_pixel_ready      = (pix_count_q < FULL);
   assign wr_en              = i_pixel_data_valid && o_pixel_ready;
   assign rd_last            = rd_en && (rd_ptr_q == LAST);
   assign o_pixel_data       = win_q;
   assign o_pixel_data_valid = vld_q;
   assign o_intr             = intr_q;

   // Scheduler: wait for three buffered lines, then read exactly one line.
   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: if (pix_count_q >= THREE) state_d = RD;
         RD: begin
            rd_en = 1'b1;
            if (rd_ptr_q == LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Write/read pointer advance and occupancy bookkeeping.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      wr_lb_d     = wr_lb_q;
      rd_ptr_d    = rd_ptr_q;
      rd_lb_d     = rd_lb_q;
      pix_count_d = pix_count_q;
      if (wr_en) begin
         if (wr_ptr_q == LAST) begin
            wr_ptr_d = '0;
            wr_lb_d  = wr_lb_q + 2'd1;
         end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
      end
      if (rd_en) begin
         if (rd_last) begin
            rd_ptr_d = '0;
            rd_lb_d  = rd_lb_q + 2'd1;
         end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
      end
      case ({wr_en, rd_en})
         2'b10:   pix_count_d = pix_count_q + CW'(1);
         2'b01:   pix_count_d = pix_count_q - CW'(1);
         default: pix_count_d = pix_count_q;
      endcase
   end

   // Gather the 3x3 window; columns past the right edge reuse the last pixel.
   always_comb begin
      win_d = '0;
      lb    = '0;
      col   = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            lb  = rd_lb_q + 2'(r);
            col = {1'b0, rd_ptr_q} + (PW+1)'(c);
            if (col > LASTX) col = LASTX;
            win_d[(3*r+c)*8 +: 8] = mem_q[lb][col[PW-1:0]];
         end
      end
   end

   // Line buffer storage; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem_q[wr_lb_q][wr_ptr_q] <= i_pixel_data;
   end

   // Control state registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         wr_lb_q     <= '0;
         wr_ptr_q    <= '0;
         rd_lb_q     <= '0;
         rd_ptr_q    <= '0;
         pix_count_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_lb_q     <= wr_lb_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_lb_q     <= rd_lb_d;
         rd_ptr_q    <= rd_ptr_d;
         pix_count_q <= pix_count_d;
      end
   end

   // Registered window output; data holds while no read is in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         win_q  <= '0;
         vld_q  <= 1'b0;
         intr_q <= 1'b0;
      end else begin
         vld_q  <= rd_en;
         intr_q <= rd_last;
         if (rd_en) win_q <= win_d;
      end
   end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl at IMG_WIDTH=8. A negedge monitor keeps the
// stream of accepted pixels and derives every expected window, ready level
// and interrupt from it; a table of scenarios plus directed sequences drive it.
module tb_conv_window_ctrl;

   localparam int W = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  din = '0;
   logic        din_vld = 1'b0;
   logic        rdy;
   logic [71:0] dout;
   logic        dout_vld;
   logic        intr;

   conv_window_ctrl #(.IMG_WIDTH(W)) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_pixel_data       (din),
      .i_pixel_data_valid (din_vld),
      .o_pixel_ready      (rdy),
      .o_pixel_data       (dout),
      .o_pixel_data_valid (dout_vld),
      .o_intr             (intr)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   byte unsigned acc[$];          // every pixel the block accepted since reset
   int           win_total = 0;   // windows seen since reset
   int           intr_cnt  = 0;
   int           run_len   = 0;
   int           bp_cycles = 0;
   logic [71:0]  sig = '0;
   int           occ, wp, wx;

   // Pass p reads lines p..p+2 of the accepted stream, window x at column x.
   function automatic logic [71:0] exp_win(input int p, input int x);
      logic [71:0] w;
      int col, idx;
      w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            col = (x + c > W - 1) ? W - 1 : x + c;
            idx = (p + r) * W + col;
            if (idx < acc.size()) w[(3*r+c)*8 +: 8] = acc[idx];
         end
      return w;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ready", 72'(rdy), 72'(1));
         chk("rst_valid", 72'(dout_vld), 72'(0));
         chk("rst_intr",  72'(intr), 72'(0));
         chk("rst_data",  dout, 72'(0));
         acc.delete();
         win_total = 0; intr_cnt = 0; run_len = 0; bp_cycles = 0; sig = '0;
      end else begin
         occ = acc.size() - win_total - (dout_vld ? 1 : 0);
         chk("ready", 72'(rdy), 72'(occ < 4*W));
         if (!rdy) bp_cycles++;
         if (dout_vld) begin
            wp = win_total / W;
            wx = win_total % W;
            chk("win_src", 72'((wp + 3) * W <= acc.size()), 72'(1));
            chk("window", dout, exp_win(wp, wx));
            chk("intr_last", 72'(intr), 72'(wx == W - 1));
            sig = {sig[70:0], sig[71]} ^ dout;
            win_total++;
            run_len++;
            if (intr) intr_cnt++;
         end else begin
            chk("intr_idle", 72'(intr), 72'(0));
            if (run_len != 0) chk("run_len", 72'(run_len), 72'(W));
            run_len = 0;
         end
         if (din_vld && rdy) acc.push_back(din);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pix(input int i, input int key);
      if (key == 0) return 8'(16 * (i / W) + (i % W));
      return 8'(i * key + (i / W) * 13 + 7);
   endfunction

   task automatic do_reset();
      rst_n   = 1'b0;
      din_vld = 1'b0;
      #1;
      chk("rst_imm_ready", 72'(rdy), 72'(1));
      chk("rst_imm_valid", 72'(dout_vld), 72'(0));
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Pixels that meet ready=0 are replaced by junk that must be dropped.
   task automatic send_pixels(input int n, input int key, input int gap);
      int guard;
      for (int i = 0; i < n; i++) begin
         for (int g = 0; g < 4 && gap > 0 && int'($urandom_range(0, 99)) < gap; g++) begin
            din_vld = 1'b0;
            tick();
         end
         guard = 0;
         while (!rdy && guard < 500) begin
            din_vld = 1'b1;
            din     = 8'($urandom);
            tick();
            guard++;
         end
         if (!rdy) chk("ready_timeout", 72'(rdy), 72'(1));
         din_vld = 1'b1;
         din     = pix(i, key);
         tick();
      end
      din_vld = 1'b0;
   endtask

   typedef struct {
      int lines;
      int gap;
      int key;
      int exp_pass;
      int exp_bp;    // 1/0 = backpressure expected or not, -1 = don't care
      int same;      // index of an earlier run with identical data, -1 = none
   } scen_t;

   initial begin
      scen_t       tab [5];
      logic [71:0] sig_tab [5];

      tab[0] = '{2,  0,  3, 0,  0, -1};
      tab[1] = '{3,  30, 3, 1, -1, -1};
      tab[2] = '{6,  0,  5, 4, -1, -1};
      tab[3] = '{6,  50, 5, 4, -1,  2};
      tab[4] = '{14, 0,  9, 12, 1, -1};

      // Fill three lines with 16*line+col and check exact timing and edges.
      do_reset();
      send_pixels(3 * W, 0, 0);
      chk("t1_idle0", 72'(dout_vld), 72'(0));
      tick();
      chk("t1_idle1", 72'(dout_vld), 72'(0));
      tick();
      chk("t1_first_vld", 72'(dout_vld), 72'(1));
      chk("t1_first_win", dout, 72'h22_21_20_12_11_10_02_01_00);
      repeat (W - 1) tick();
      chk("t1_last_vld", 72'(dout_vld), 72'(1));
      chk("t1_last_win", dout, 72'h27_27_27_17_17_17_07_07_07);
      chk("t1_last_intr", 72'(intr), 72'(1));
      tick();
      chk("t1_after_vld", 72'(dout_vld), 72'(0));
      chk("t1_hold_win", dout, 72'h27_27_27_17_17_17_07_07_07);
      repeat (4) tick();
      chk("t1_intr_cnt", 72'(intr_cnt), 72'(1));
      chk("t1_windows", 72'(win_total), 72'(W));

      // Asynchronous reset in the middle of a pass, at rd_ptr=3.
      do_reset();
      send_pixels(3 * W, 7, 0);
      repeat (4) tick();
      chk("t2_mid_vld", 72'(dout_vld), 72'(1));
      rst_n = 1'b0;
      #1;
      chk("t2_rst_ready", 72'(rdy), 72'(1));
      chk("t2_rst_vld", 72'(dout_vld), 72'(0));
      chk("t2_rst_intr", 72'(intr), 72'(0));
      chk("t2_rst_data", dout, 72'(0));
      tick();
      tick();
      rst_n = 1'b1;
      send_pixels(2 * W, 11, 0);
      repeat (20) tick();
      chk("t2_no_win", 72'(win_total), 72'(0));
      chk("t2_no_intr", 72'(intr_cnt), 72'(0));
      send_pixels(W, 11, 0);
      repeat (W + 10) tick();
      chk("t2_windows", 72'(win_total), 72'(W));
      chk("t2_intr", 72'(intr_cnt), 72'(1));

      // Table-driven streams: pass counts, backpressure, gap invariance.
      for (int s = 0; s < 5; s++) begin
         do_reset();
         send_pixels(tab[s].lines * W, tab[s].key, tab[s].gap);
         repeat (6 * W + 20) tick();
         chk("scen_intr", 72'(intr_cnt), 72'(tab[s].exp_pass));
         chk("scen_windows", 72'(win_total), 72'(tab[s].exp_pass * W));
         if (tab[s].exp_bp >= 0)
            chk("scen_backpressure", 72'(bp_cycles > 0), 72'(tab[s].exp_bp));
         if (tab[s].same >= 0)
            chk("scen_gap_invariant", sig, sig_tab[tab[s].same]);
         sig_tab[s] = sig;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
